register_file_ext: RTL

REGISTER_FILE_EXT -- requirements
Module: register_file_ext

---
 rtl/register_file_ext.sv | 95 +++++++++
 1 files changed

// File: rtl/register_file_ext.sv
// Multi-port register file: two combinational reads, byte-lane write port A, full-word write port B, clear sweep.
// Latency: writes are visible one cycle later (same cycle when REGISTER_FILE_EXT_BYPASS_EN is defined).
// Backpressure: o_ready is low during the DEPTH-cycle clear sweep; writes are dropped and reads return 0.
module register_file_ext #(
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 4,
  localparam int LANES  = DATA_W / 8,
  localparam int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear_req,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_rd1_addr,
  input  logic [ADDR_W-1:0] i_rd2_addr,
  output logic [DATA_W-1:0] o_rd1_data,
  output logic [DATA_W-1:0] o_rd2_data,
  input  logic [ADDR_W-1:0] i_wa_addr,
  input  logic [LANES-1:0]  i_wa_be,
  input  logic [DATA_W-1:0] i_wa_data,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data
);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [ADDR_W-1:0] w_clr_ptr_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      ST_CLEAR: begin
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt   = ST_READY;
          w_clr_ptr_nxt = '0;
        end
      end
      default: begin
        if (i_clear_req) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_ptr_nxt = '0;
        end
      end
    endcase
  end

  assign o_ready = (r_state == ST_READY);

  // Port B is applied last so it overrides port A on shared lanes.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (i_wa_be[i]) r_mem[i_wa_addr][i*8 +: 8] <= i_wa_data[i*8 +: 8];
      end
      if (i_wb_en) r_mem[i_wb_addr] <= i_wb_data;
    end
  end

  always_comb begin
    w_rd1 = r_mem[i_rd1_addr];
    w_rd2 = r_mem[i_rd2_addr];
`ifdef REGISTER_FILE_EXT_BYPASS_EN
    for (int i = 0; i < LANES; i++) begin
      if (i_wb_en && (i_wb_addr == i_rd1_addr))          w_rd1[i*8 +: 8] = i_wb_data[i*8 +: 8];
      else if (i_wa_be[i] && (i_wa_addr == i_rd1_addr))  w_rd1[i*8 +: 8] = i_wa_data[i*8 +: 8];
      if (i_wb_en && (i_wb_addr == i_rd2_addr))          w_rd2[i*8 +: 8] = i_wb_data[i*8 +: 8];
      else if (i_wa_be[i] && (i_wa_addr == i_rd2_addr))  w_rd2[i*8 +: 8] = i_wa_data[i*8 +: 8];
    end
`endif
    o_rd1_data = o_ready ? w_rd1 : '0;
    o_rd2_data = o_ready ? w_rd2 : '0;
  end

endmodule
